dma_copy_engine: RTL

DMA_COPY_ENGINE -- requirements
Module: dma_copy_engine

---
 rtl/dma_copy_engine.sv | 133 +++++++++++++
 1 files changed

// File: rtl/dma_copy_engine.sv
// Single-channel word copy engine sharing the data-memory port with the CPU.
// The CPU's MEM stage always has priority; the DMA stalls in READ/WRITE while cpu_mem_req is high.
//
// state | meaning
// IDLE  | waiting for start; checks alignment and zero length
// READ  | issue read of src_ptr when the port is free
// WAIT  | capture read data, advance src_ptr
// WRITE | issue write of data_buf to dst_ptr when the port is free
// DONE  | one-cycle completion pulse
module dma_copy_engine (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] cfg_src,
    input  logic [31:0] cfg_dst,
    input  logic [15:0] cfg_len,
    input  logic        start,
    input  logic        cpu_mem_req,
    input  logic [31:0] mem_rdata,
    output logic [31:0] mem_addr,
    output logic        mem_read_en,
    output logic        mem_write_en,
    output logic [31:0] mem_wdata,
    output logic        grant_dma,
    output logic        busy,
    output logic        done,
    output logic        err
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        READ  = 3'd1,
        WAIT  = 3'd2,
        WRITE = 3'd3,
        DONE  = 3'd4
    } state_t;

    state_t      state, state_nxt;
    logic [31:0] src_ptr, src_ptr_nxt;
    logic [31:0] dst_ptr, dst_ptr_nxt;
    logic [15:0] remaining, remaining_nxt;
    logic [31:0] data_buf, data_buf_nxt;
    logic        err_q, err_nxt;
    logic        zdone_q, zdone_nxt;
    logic        aligned;

    assign aligned = (cfg_src[1:0] == 2'b00) && (cfg_dst[1:0] == 2'b00);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            src_ptr   <= 32'd0;
            dst_ptr   <= 32'd0;
            remaining <= 16'd0;
            data_buf  <= 32'd0;
            err_q     <= 1'b0;
            zdone_q   <= 1'b0;
        end else begin
            state     <= state_nxt;
            src_ptr   <= src_ptr_nxt;
            dst_ptr   <= dst_ptr_nxt;
            remaining <= remaining_nxt;
            data_buf  <= data_buf_nxt;
            err_q     <= err_nxt;
            zdone_q   <= zdone_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        src_ptr_nxt   = src_ptr;
        dst_ptr_nxt   = dst_ptr;
        remaining_nxt = remaining;
        data_buf_nxt  = data_buf;
        err_nxt       = 1'b0;
        zdone_nxt     = 1'b0;
        mem_addr      = 32'd0;
        mem_read_en   = 1'b0;
        mem_write_en  = 1'b0;
        mem_wdata     = 32'd0;

        unique case (state)
            IDLE: begin
                if (start) begin
                    // Misalignment is reported even when the length is zero.
                    if (!aligned) begin
                        err_nxt = 1'b1;
                    end else if (cfg_len == 16'd0) begin
                        zdone_nxt = 1'b1;
                    end else begin
                        src_ptr_nxt   = cfg_src;
                        dst_ptr_nxt   = cfg_dst;
                        remaining_nxt = cfg_len;
                        state_nxt     = READ;
                    end
                end
            end
            READ: begin
                if (!cpu_mem_req) begin
                    mem_read_en = 1'b1;
                    mem_addr    = src_ptr;
                    state_nxt   = WAIT;
                end
            end
            WAIT: begin
                data_buf_nxt = mem_rdata;
                src_ptr_nxt  = src_ptr + 32'd4;
                state_nxt    = WRITE;
            end
            WRITE: begin
                if (!cpu_mem_req) begin
                    mem_write_en  = 1'b1;
                    mem_addr      = dst_ptr;
                    mem_wdata     = data_buf;
                    dst_ptr_nxt   = dst_ptr + 32'd4;
                    remaining_nxt = remaining - 16'd1;
                    state_nxt     = (remaining == 16'd1) ? DONE : READ;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign grant_dma = mem_read_en | mem_write_en;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE) | zdone_q;
    assign err       = err_q;

endmodule
